arrow_key_decoder: RTL and testbench
====================================

// Module: arrow_key_decoder
// PURPOSE
//  Converts the keyboard scan-code byte stream into the four held-level arrow
//  signals leftArrow/rightArrow/upArrow/downArrow that drive the player movement
//  block. Sits between the PS/2 byte receiver and player movement logic.
//  Tracks make/break codes, E0-extended codes and the E1 pause sequence.
//  Recovers from truncated sequences with a timeout.
// PARAMETERS
//  ACCEPT_KEYPAD   1       1: also accept non-extended keypad arrows 6B/74/75/72 (NumLock off)
//  TIMEOUT_CYCLES  50000   clk cycles without a byte, in a non-IDLE state, before abort (2 ms @ 25 MHz)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  din          in   8  scan-code byte from PS/2 receiver
//  din_new      in   1  din valid; every high cycle counts as one byte
//  leftArrow    out  1  left arrow held (level)
//  rightArrow   out  1  right arrow held (level)
//  upArrow      out  1  up arrow held (level)
//  downArrow    out  1  down arrow held (level)
//  key_event    out  1  1-cycle pulse when any arrow output changes
//  err_timeout  out  1  1-cycle pulse when a partial sequence is aborted by timeout
// BEHAVIOUR
//  - Interface: one clock (clk). reset is asynchronous and active-high.
//  - Reset: all outputs 0, FSM=IDLE, timeout counter=0, pause count=0. Applies immediately, even mid-sequence.
//  - Arrow codes (same byte with or without E0): left=6B, right=74, up=75, down=72.
//  - Latency: outputs are registered. An arrow changes on the clk edge after the din_new cycle carrying the final byte.
//  - FSM, evaluated only on din_new cycles:
//    IDLE:    E0->EXT; F0->BRK; E1->PAUSE (cnt=7).
//             AA or FC -> clear all arrows, stay IDLE.
//             Arrow code with ACCEPT_KEYPAD=1 -> set that arrow. Any other byte -> ignore.
//    EXT:     F0->EXT_BRK; E0->stay EXT; arrow code->set arrow, IDLE; other (e.g. 12 fake shift)->IDLE.
//    BRK:     arrow code with ACCEPT_KEYPAD=1->clear arrow; then IDLE for any byte.
//    EXT_BRK: arrow code->clear arrow; then IDLE for any byte.
//    PAUSE:   decrement cnt per byte. IDLE when cnt reaches 0 (7 bytes after E1 swallowed). No arrow change.
//  - Overrun: byte 00 or FF in any state -> clear all arrows, IDLE. Takes priority over the table above.
//  - Setting an already-set arrow, or clearing a cleared one, is not a change: no key_event.
//  - Opposite arrows may be 1 together; no arbitration here (the consumer resolves it).
//  - key_event = OR over the four arrows of (new != old); asserted in the same cycle the outputs change.
//  - Timeout counter:
//    * Cleared on every din_new and while in IDLE; otherwise increments each cycle, saturating.
//    * Reaches TIMEOUT_CYCLES-1 with no din_new -> IDLE next edge, err_timeout=1 for exactly that cycle.
//    * Arrows and pause count are unchanged, except that PAUSE is abandoned.
//    * din_new in the abort cycle wins: byte processed normally, no err_timeout.
//  - Counter width = $clog2(TIMEOUT_CYCLES+1). Pause count is 3 bits.
// TESTING
//  1. Bytes E0,6B -> leftArrow=1 one edge after the 2nd din_new, key_event 1 cycle.
//     Then E0,F0,6B -> leftArrow=0, key_event 1 cycle.
//  2. ACCEPT_KEYPAD=1: 74 -> rightArrow=1; F0,74 -> rightArrow=0.
//     ACCEPT_KEYPAD=0: 74 -> no change, no key_event.
//  3. E0 then idle TIMEOUT_CYCLES cycles -> err_timeout single pulse, FSM IDLE.
//     Next 6B with ACCEPT_KEYPAD=0 -> no change.
//  4. E1,14,77,E1,F0,14,F0,77 -> no arrow change, no key_event.
//     Next E0,75 -> upArrow=1.
//  5. Hold up+down (E0,75,E0,72), send AA -> all arrows 0, one key_event.
//     Repeat the hold, then E0,FF -> all 0, FSM IDLE.
//  6. Assert reset between E0 and 72 -> outputs 0 asynchronously.
//     Release, send 72 with ACCEPT_KEYPAD=0 -> downArrow stays 0.

Source files
------------

// File: rtl/arrow_key_decoder.sv
// PS/2 scan-code stream to held-level arrow key signals.
// Tracks make/break, E0-extended and E1 pause sequences and aborts stalled sequences.
module arrow_key_decoder #(
    parameter bit          ACCEPT_KEYPAD  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic       leftArrow,
    output logic       rightArrow,
    output logic       upArrow,
    output logic       downArrow,
    output logic       key_event,
    output logic       err_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t        state, state_nx;
    logic [3:0]    arrows, arrows_nx;   // {left, right, up, down}
    logic [3:0]    mask;
    logic          is_arrow;
    logic [2:0]    pcnt, pcnt_nx;
    logic [CW-1:0] tcnt;
    logic          abort;

    always_comb begin
        case (din)
            8'h6B:   mask = 4'b1000;
            8'h74:   mask = 4'b0100;
            8'h75:   mask = 4'b0010;
            8'h72:   mask = 4'b0001;
            default: mask = 4'b0000;
        endcase
        is_arrow = |mask;
    end

    always_comb begin
        state_nx  = state;
        arrows_nx = arrows;
        pcnt_nx   = pcnt;
        abort     = 1'b0;
        if (din_new) begin
            // Overrun bytes override whatever sequence is in progress
            if (din == 8'h00 || din == 8'hFF) begin
                arrows_nx = '0;
                state_nx  = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (din == 8'hE0) begin
                            state_nx = EXT;
                        end else if (din == 8'hF0) begin
                            state_nx = BRK;
                        end else if (din == 8'hE1) begin
                            state_nx = PAUSE;
                            pcnt_nx  = 3'd7;
                        end else if (din == 8'hAA || din == 8'hFC) begin
                            arrows_nx = '0;
                        end else if (ACCEPT_KEYPAD && is_arrow) begin
                            arrows_nx = arrows | mask;
                        end
                    end
                    EXT: begin
                        if (din == 8'hF0) begin
                            state_nx = EXT_BRK;
                        end else if (din != 8'hE0) begin
                            if (is_arrow) arrows_nx = arrows | mask;
                            state_nx = IDLE;
                        end
                    end
                    BRK: begin
                        if (ACCEPT_KEYPAD && is_arrow) arrows_nx = arrows & ~mask;
                        state_nx = IDLE;
                    end
                    EXT_BRK: begin
                        if (is_arrow) arrows_nx = arrows & ~mask;
                        state_nx = IDLE;
                    end
                    PAUSE: begin
                        pcnt_nx = pcnt - 3'd1;
                        if (pcnt <= 3'd1) state_nx = IDLE;
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end else if (state != IDLE && tcnt == TLAST) begin
            state_nx = IDLE;
            abort    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            arrows      <= '0;
            pcnt        <= '0;
            tcnt        <= '0;
            key_event   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            arrows      <= arrows_nx;
            pcnt        <= pcnt_nx;
            key_event   <= |(arrows_nx ^ arrows);
            err_timeout <= abort;
            if (din_new || state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign leftArrow  = arrows[3];
    assign rightArrow = arrows[2];
    assign upArrow    = arrows[1];
    assign downArrow  = arrows[0];

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Directed bench: one decoder with keypad arrows accepted, one without, fed the same bytes.
module tb_arrow_key_decoder;

    localparam int unsigned T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_new;

    logic k_left, k_right, k_up, k_down, k_ke, k_err;
    logic n_left, n_right, n_up, n_down, n_ke, n_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned kek = 0, ken = 0, erk = 0, ern = 0;

    arrow_key_decoder #(.ACCEPT_KEYPAD(1'b1), .TIMEOUT_CYCLES(T)) u_kp (
        .clk(clk), .reset(reset), .din(din), .din_new(din_new),
        .leftArrow(k_left), .rightArrow(k_right), .upArrow(k_up), .downArrow(k_down),
        .key_event(k_ke), .err_timeout(k_err)
    );

    arrow_key_decoder #(.ACCEPT_KEYPAD(1'b0), .TIMEOUT_CYCLES(T)) u_nk (
        .clk(clk), .reset(reset), .din(din), .din_new(din_new),
        .leftArrow(n_left), .rightArrow(n_right), .upArrow(n_up), .downArrow(n_down),
        .key_event(n_ke), .err_timeout(n_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ak();
        return {28'd0, k_left, k_right, k_up, k_down};
    endfunction

    function automatic logic [31:0] an();
        return {28'd0, n_left, n_right, n_up, n_down};
    endfunction

    // One clock cycle; pulses are tallied once per cycle at the falling edge
    task automatic tick();
        @(negedge clk);
        if (k_ke)  kek++;
        if (n_ke)  ken++;
        if (k_err) erk++;
        if (n_err) ern++;
    endtask

    task automatic clr();
        kek = 0; ken = 0; erk = 0; ern = 0;
    endtask

    task automatic send(input logic [7:0] b);
        din     = b;
        din_new = 1'b1;
        tick();
        din_new = 1'b0;
        din     = 8'h00;
    endtask

    initial begin
        reset   = 1'b1;
        din     = 8'h00;
        din_new = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_arrows_k", ak(), 0);
        check("rst_arrows_n", an(), 0);
        check("rst_ke", {30'd0, k_ke, n_ke}, 0);
        check("rst_err", {30'd0, k_err, n_err}, 0);

        // Extended make then break of left
        clr();
        send(8'hE0);
        check("e0_only", ak(), 0);
        send(8'h6B);
        check("ext_left_k", ak(), 4'b1000);
        check("ext_left_n", an(), 4'b1000);
        check("ext_left_ke", {30'd0, k_ke, n_ke}, 2'b11);
        tick();
        check("ke_one_cycle", {30'd0, k_ke, n_ke}, 0);
        clr();
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("ext_brk_k", ak(), 0);
        check("ext_brk_n", an(), 0);
        check("ext_brk_kecnt", kek, 1);

        // Keypad arrows without E0
        clr();
        send(8'h74);
        check("kp_right_k", ak(), 4'b0100);
        check("kp_right_n", an(), 0);
        check("kp_right_ke", {kek[15:0], ken[15:0]}, 32'h0001_0000);
        clr();
        send(8'hF0); send(8'h74);
        check("kp_brk_k", ak(), 0);
        check("kp_brk_ke", {kek[15:0], ken[15:0]}, 32'h0001_0000);

        // Timeout after a lone E0
        clr();
        send(8'hE0);
        for (int i = 0; i < int'(T) - 1; i++) tick();
        check("to_early", erk + ern, 0);
        tick();
        check("to_pulse", {30'd0, k_err, n_err}, 2'b11);
        tick(); tick(); tick();
        check("to_single", {erk[15:0], ern[15:0]}, 32'h0001_0001);
        clr();
        send(8'h6B);
        check("to_idle_k", ak(), 4'b1000);
        check("to_idle_n", an(), 0);
        check("to_idle_ke", {kek[15:0], ken[15:0]}, 32'h0001_0000);
        send(8'hF0); send(8'h6B);
        check("to_clr_k", ak(), 0);

        // A byte in the abort cycle is processed and suppresses the timeout
        clr();
        send(8'hE0);
        for (int i = 0; i < int'(T) - 1; i++) tick();
        send(8'h6B);
        check("abort_win_k", ak(), 4'b1000);
        check("abort_win_n", an(), 4'b1000);
        tick(); tick(); tick();
        check("abort_win_err", erk + ern, 0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("abort_clr", ak() | an(), 0);

        // Pause sequence is swallowed whole
        clr();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_arrows", ak() | an(), 0);
        check("pause_ke", kek + ken, 0);
        send(8'hE0); send(8'h75);
        check("pause_up_k", ak(), 4'b0010);
        check("pause_up_n", an(), 4'b0010);

        // Opposite arrows together, then AA clears
        clr();
        send(8'hE0); send(8'h72);
        check("updown_k", ak(), 4'b0011);
        check("updown_n", an(), 4'b0011);
        check("updown_ke", kek, 1);
        clr();
        send(8'hAA);
        check("aa_clr_k", ak(), 0);
        check("aa_clr_n", an(), 0);
        check("aa_ke", {30'd0, k_ke, n_ke}, 2'b11);
        tick();
        check("aa_ke_once", {kek[15:0], ken[15:0]}, 32'h0001_0001);

        // Overrun byte mid-sequence
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        check("hold2_k", ak(), 4'b0011);
        send(8'hE0); send(8'hFF);
        check("ff_clr_k", ak(), 0);
        check("ff_clr_n", an(), 0);
        send(8'h72);
        check("ff_idle_k", ak(), 4'b0001);
        check("ff_idle_n", an(), 0);
        send(8'hF0); send(8'h72);
        check("ff_kp_brk", ak(), 0);

        // Asynchronous reset between E0 and 72
        send(8'hE0); send(8'h72);
        check("pre_rst_n", an(), 4'b0001);
        send(8'hE0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_k", ak(), 0);
        check("async_rst_n", an(), 0);
        tick();
        tick();
        reset = 1'b0;
        send(8'h72);
        check("post_rst_n", an(), 0);
        check("post_rst_k", ak(), 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
